iopage_master: RTL and testbench
================================

# iopage_master

CPU-side initiator for the PDP-11 I/O page bus. It accepts one register access at a time from the CPU datapath and drives the shared iopage address, data and strobe lines that every I/O-page slave (line clock, console, disk and others) responds to. It waits for a slave decode, performs one read or write strobe, and returns either read data with an acknowledge, a non-existent-memory (NXM) error, or an odd-address error. It sits between the CPU bus unit and the OR-combined slave bank.

## Interface
- TIMEOUT_CYCLES, 8: number of SETUP cycles without decode before NXM. Used only with IOPAGE_TIMEOUT_EN. Legal range 1..255.

- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset; clock clk
- cpu_req  in  1  access request; sampled only in IDLE
- cpu_addr  in  13  I/O-page byte offset
- cpu_wr  in  1  1 = write, 0 = read
- cpu_byte  in  1  byte access
- cpu_wdata  in  16  write data; byte data in [7:0]
- cpu_rdata  out  16  read result; held until the next successful read
- cpu_ack  out  1  one-cycle success pulse
- cpu_nxm  out  1  one-cycle no-decode error pulse
- cpu_odd  out  1  one-cycle odd-word-address error pulse
- busy  out  1  high in every state except IDLE
- iopage_addr  out  13  word-aligned address: {addr[12:1],1'b0}
- iopage_data_out  out  16  write data to slaves' data_in
- iopage_rd  out  1  read strobe
- iopage_wr  out  1  write strobe
- iopage_byte_op  out  1  latched cpu_byte
- iopage_hibyte  out  1  byte op targets the high lane (addr[0] & byte)
- iopage_decode  in  1  OR of all slave decode outputs
- iopage_data_in  in  16  OR of all slave data_out buses

## Operation
- States: IDLE, SETUP, XFER, DONE, ERR, ODD.
- IDLE: when cpu_req=1, latch addr, wr, byte and wdata.
  - Word access with addr[0]=1 goes to ODD.
  - Any other access goes to SETUP.
  - cpu_req while busy is ignored; it is not queued.
- SETUP: iopage_addr, iopage_byte_op, iopage_hibyte and iopage_data_out are driven from the latches. Strobes stay low. iopage_decode is sampled.
  - Decode=1: go to XFER.
  - Decode=0: go to ERR. See Configuration for the timeout variant.
- XFER: exactly one cycle with iopage_rd=1 for a read or iopage_wr=1 for a write. Address and data stay stable.
  - Reads capture iopage_data_in at the end of the cycle.
  - Go to DONE.
- DONE: cpu_ack=1 for one cycle, then IDLE.
- ERR: cpu_nxm=1 for one cycle, then IDLE. No strobe is issued and cpu_rdata is unchanged.
- ODD: cpu_odd=1 for one cycle, then IDLE. No strobe is issued and the bus lines are not updated.
- Read data formatting:
  - Word read: rdata = data_in.
  - Even byte read: rdata = {8'b0, data_in[7:0]}.
  - Odd byte read: rdata = {8'b0, data_in[15:8]}.
- Write data formatting:
  - Word write: data_out = wdata.
  - Byte write: data_out = {wdata[7:0], wdata[7:0]}, the byte replicated on both lanes. Slaves select the lane using iopage_hibyte.
- The address bus holds its last value in IDLE. Strobes are never asserted outside XFER.

## Timing
- Reset values: every output is 0 (cpu_rdata, iopage_addr and iopage_data_out included), and the state is IDLE.
- Reset in any state returns to IDLE at the next edge. No ack, nxm or odd pulse is produced for the aborted access, and strobes drop immediately.
- Success path: cpu_req is sampled at edge 0, SETUP runs in cycle 1, XFER in cycle 2, and ack in cycle 3. Latency is 3 cycles.
- The earliest next request is sampled at the edge that ends DONE.
- Error paths:
  - Odd address: cpu_odd in cycle 1.
  - NXM without macro: cpu_nxm in cycle 2.
- Slaves are combinational on reads and registered on writes. The write takes effect at the edge that ends XFER.

## Configuration
- IOPAGE_TIMEOUT_EN defined:
  - SETUP holds while decode=0, counting cycles in an 8-bit counter that is cleared on entry to SETUP.
  - If decode rises before the count reaches TIMEOUT_CYCLES, go to XFER.
  - After TIMEOUT_CYCLES SETUP cycles with no decode, go to ERR. cpu_nxm appears in cycle TIMEOUT_CYCLES+1 after the request.
  - This tolerates slaves with registered decode.
- IOPAGE_TIMEOUT_EN undefined:
  - The counter is not built.
  - A single SETUP cycle decides: decode=0 goes straight to ERR.

## Test plan
- Word write to 13'o17546 (wdata 16'o000100), slave decodes. Required response: one-cycle iopage_wr in cycle 2 with data_out=16'o000100 and addr=13'o17546, cpu_ack in cycle 3, and slave CSR reads 16'o000100 afterwards.
- Word read of 13'o17546 with slave returning 16'h1234. Required response: iopage_rd only in cycle 2, cpu_rdata=16'h1234 together with cpu_ack in cycle 3.
- Byte read of 13'o17547 with slave data 16'h1234. Required response: iopage_addr=13'o17546 and iopage_hibyte=1, then cpu_rdata=16'h0012 with ack. The same read at 13'o17546 returns 16'h0034.
- Byte write of 13'o17547 with wdata 16'h00AB. Required response: data_out=16'hABAB, hibyte=1, byte_op=1, and one wr pulse.
- Undecoded address 13'o00000. Required response: no strobe, and cpu_nxm in cycle 9 with macro on (TIMEOUT_CYCLES=8) or in cycle 2 with macro off. cpu_rdata is unchanged. Word read of 13'o17547 gives cpu_odd in cycle 1 and no bus activity.
- Reset asserted during SETUP, and separately during XFER. Required response: strobes drop, no ack, nxm or odd pulse, busy=0 after the edge, and a following request completes normally.

Source files
------------

// File: rtl/iopage_master.sv
// iopage_master: CPU-side initiator for the PDP-11 I/O page bus (one access at a time).
// Latency: request edge 0, SETUP cycle 1, XFER cycle 2, ack cycle 3; odd error cycle 1, NXM cycle 2.
// Backpressure: busy is high outside IDLE and requests seen while busy are dropped; the
// optional macro IOPAGE_TIMEOUT_EN makes SETUP wait up to TIMEOUT_CYCLES for a decode.
module iopage_master
`ifdef IOPAGE_TIMEOUT_EN
#(
  parameter int unsigned TIMEOUT_CYCLES = 8
)
`endif
(
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic [12:0] cpu_addr,
  input  logic        cpu_wr,
  input  logic        cpu_byte,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic        cpu_ack,
  output logic        cpu_nxm,
  output logic        cpu_odd,
  output logic        busy,
  output logic [12:0] iopage_addr,
  output logic [15:0] iopage_data_out,
  output logic        iopage_rd,
  output logic        iopage_wr,
  output logic        iopage_byte_op,
  output logic        iopage_hibyte,
  input  logic        iopage_decode,
  input  logic [15:0] iopage_data_in
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    XFER  = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4,
    ODD   = 3'd5
  } state_t;

  state_t      state_q;
  logic [15:0] rdata_q;
  logic        ack_q;
  logic        nxm_q;
  logic        odd_q;
  logic [12:0] addr_q;
  logic [15:0] data_out_q;
  logic        rd_q;
  logic        wr_q;
  logic        byte_q;
  logic        hibyte_q;
  logic        write_q;

`ifdef IOPAGE_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] cnt_q;
`endif

  logic [15:0] data_out_d;
  logic [15:0] rdata_d;

  // Format the outgoing write data (byte replicated on both lanes) and the incoming read data
  always_comb begin
    data_out_d = cpu_byte ? {cpu_wdata[7:0], cpu_wdata[7:0]} : cpu_wdata;
    rdata_d    = iopage_data_in;
    if (byte_q) begin
      rdata_d = hibyte_q ? {8'b0, iopage_data_in[15:8]} : {8'b0, iopage_data_in[7:0]};
    end
  end

  // Access sequencer; every output is a register so the shared bus sees clean edges
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      rdata_q    <= '0;
      ack_q      <= 1'b0;
      nxm_q      <= 1'b0;
      odd_q      <= 1'b0;
      addr_q     <= '0;
      data_out_q <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      byte_q     <= 1'b0;
      hibyte_q   <= 1'b0;
      write_q    <= 1'b0;
`ifdef IOPAGE_TIMEOUT_EN
      cnt_q      <= '0;
`endif
    end else begin
      ack_q <= 1'b0;
      nxm_q <= 1'b0;
      odd_q <= 1'b0;
      rd_q  <= 1'b0;
      wr_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cpu_req) begin
            if (!cpu_byte && cpu_addr[0]) begin
              // Odd word address: report at once and leave the bus lines untouched
              state_q <= ODD;
              odd_q   <= 1'b1;
            end else begin
              state_q    <= SETUP;
              addr_q     <= {cpu_addr[12:1], 1'b0};
              data_out_q <= data_out_d;
              byte_q     <= cpu_byte;
              hibyte_q   <= cpu_addr[0] & cpu_byte;
              write_q    <= cpu_wr;
`ifdef IOPAGE_TIMEOUT_EN
              cnt_q      <= '0;
`endif
            end
          end
        end
        SETUP: begin
          if (iopage_decode) begin
            state_q <= XFER;
            rd_q    <= ~write_q;
            wr_q    <= write_q;
          end else begin
`ifdef IOPAGE_TIMEOUT_EN
            // Keep waiting for a slow (registered) decode until the budget runs out
            if (cnt_q == TIMEOUT_LAST) begin
              state_q <= ERR;
              nxm_q   <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
`else
            state_q <= ERR;
            nxm_q   <= 1'b1;
`endif
          end
        end
        XFER: begin
          if (!write_q) begin
            rdata_q <= rdata_d;
          end
          state_q <= DONE;
          ack_q   <= 1'b1;
        end
        DONE:    state_q <= IDLE;
        ERR:     state_q <= IDLE;
        ODD:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cpu_rdata       = rdata_q;
  assign cpu_ack         = ack_q;
  assign cpu_nxm         = nxm_q;
  assign cpu_odd         = odd_q;
  assign busy            = (state_q != IDLE);
  assign iopage_addr     = addr_q;
  assign iopage_data_out = data_out_q;
  // Strobes are cut combinationally by reset so an aborted access never completes on the bus
  assign iopage_rd       = rd_q & ~reset;
  assign iopage_wr       = wr_q & ~reset;
  assign iopage_byte_op  = byte_q;
  assign iopage_hibyte   = hibyte_q;

endmodule

// File: tb/tb_iopage_master.sv
// tb_iopage_master: directed bench for iopage_master with a one-register slave at 13'o17546.
// The slave decodes combinationally on the address bus and updates its CSR on the write strobe.
// Expected values are hand-computed constants; outputs are sampled 1 time unit after each edge.
module tb_iopage_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req;
  logic [12:0] cpu_addr;
  logic        cpu_wr;
  logic        cpu_byte;
  logic [15:0] cpu_wdata;
  logic [15:0] cpu_rdata;
  logic        cpu_ack;
  logic        cpu_nxm;
  logic        cpu_odd;
  logic        busy;
  logic [12:0] iopage_addr;
  logic [15:0] iopage_data_out;
  logic        iopage_rd;
  logic        iopage_wr;
  logic        iopage_byte_op;
  logic        iopage_hibyte;
  logic        iopage_decode;
  logic [15:0] iopage_data_in;

  localparam logic [12:0] CSR_ADDR = 13'o17546;

  logic [15:0] csr = 16'h0000;

  int n_pass  = 0;
  int n_total = 0;

  iopage_master dut (
    .clk             (clk),
    .reset           (reset),
    .cpu_req         (cpu_req),
    .cpu_addr        (cpu_addr),
    .cpu_wr          (cpu_wr),
    .cpu_byte        (cpu_byte),
    .cpu_wdata       (cpu_wdata),
    .cpu_rdata       (cpu_rdata),
    .cpu_ack         (cpu_ack),
    .cpu_nxm         (cpu_nxm),
    .cpu_odd         (cpu_odd),
    .busy            (busy),
    .iopage_addr     (iopage_addr),
    .iopage_data_out (iopage_data_out),
    .iopage_rd       (iopage_rd),
    .iopage_wr       (iopage_wr),
    .iopage_byte_op  (iopage_byte_op),
    .iopage_hibyte   (iopage_hibyte),
    .iopage_decode   (iopage_decode),
    .iopage_data_in  (iopage_data_in)
  );

  always #5 clk = ~clk;

  // Slave: combinational decode/read, registered write with lane select
  assign iopage_decode  = (iopage_addr == CSR_ADDR);
  assign iopage_data_in = iopage_decode ? csr : 16'h0000;

  always @(posedge clk) begin
    if (iopage_wr && iopage_decode) begin
      if (!iopage_byte_op)    csr <= iopage_data_out;
      else if (iopage_hibyte) csr[15:8] <= iopage_data_out[15:8];
      else                    csr[7:0]  <= iopage_data_out[7:0];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request for a single edge; returns in cycle 1 of the access
  task automatic do_req(input logic [12:0] a, input logic w, input logic b, input logic [15:0] d);
    cpu_req   = 1'b1;
    cpu_addr  = a;
    cpu_wr    = w;
    cpu_byte  = b;
    cpu_wdata = d;
    tick();
    cpu_req   = 1'b0;
  endtask

  int nxm_cycle;
  int strobes;
  int exp_nxm_cycle;

  initial begin
    reset     = 1'b1;
    cpu_req   = 1'b0;
    cpu_addr  = '0;
    cpu_wr    = 1'b0;
    cpu_byte  = 1'b0;
    cpu_wdata = '0;
    tick();
    tick();
    check("reset_rdata", {16'h0, cpu_rdata}, 32'h0);
    check("reset_addr", {19'h0, iopage_addr}, 32'h0);
    check("reset_dout", {16'h0, iopage_data_out}, 32'h0);
    check("reset_ctl", {24'h0, busy, cpu_ack, cpu_nxm, cpu_odd, iopage_rd, iopage_wr,
                        iopage_byte_op, iopage_hibyte}, 32'h0);
    reset = 1'b0;
    tick();

    // Word write 000100 to 17546
    do_req(13'o17546, 1'b1, 1'b0, 16'o000100);
    check("ww_c1_busy_strobes", {29'h0, busy, iopage_rd, iopage_wr}, 32'h4);
    check("ww_c1_addr", {19'h0, iopage_addr}, {19'h0, 13'o17546});
    tick();
    check("ww_c2_strobes", {30'h0, iopage_rd, iopage_wr}, 32'h1);
    check("ww_c2_dout", {16'h0, iopage_data_out}, {16'h0, 16'o000100});
    tick();
    check("ww_c3_ack_wr", {30'h0, cpu_ack, iopage_wr}, 32'h2);
    tick();
    check("ww_c4_idle", {30'h0, cpu_ack, busy}, 32'h0);
    check("ww_csr", {16'h0, csr}, {16'h0, 16'o000100});

    // Load CSR with 1234 for the read tests
    do_req(13'o17546, 1'b1, 1'b0, 16'h1234);
    tick();
    tick();
    check("ww2_ack", {31'h0, cpu_ack}, 32'h1);
    tick();

    // Word read 17546
    do_req(13'o17546, 1'b0, 1'b0, 16'h0000);
    check("wr_c1_strobes", {30'h0, iopage_rd, iopage_wr}, 32'h0);
    tick();
    check("wr_c2_strobes", {30'h0, iopage_rd, iopage_wr}, 32'h2);
    tick();
    check("wr_c3_ack", {31'h0, cpu_ack}, 32'h1);
    check("wr_c3_rdata", {16'h0, cpu_rdata}, 32'h1234);
    tick();

    // Byte read, high lane
    do_req(13'o17547, 1'b0, 1'b1, 16'h0000);
    check("brh_c1_addr", {19'h0, iopage_addr}, {19'h0, 13'o17546});
    check("brh_c1_lane", {30'h0, iopage_byte_op, iopage_hibyte}, 32'h3);
    tick();
    tick();
    check("brh_c3_ack_rdata", {15'h0, cpu_ack, cpu_rdata}, 32'h1_0012);
    tick();

    // Byte read, low lane
    do_req(13'o17546, 1'b0, 1'b1, 16'h0000);
    check("brl_c1_lane", {30'h0, iopage_byte_op, iopage_hibyte}, 32'h2);
    tick();
    tick();
    check("brl_c3_ack_rdata", {15'h0, cpu_ack, cpu_rdata}, 32'h1_0034);
    tick();

    // Byte write AB to the high lane
    do_req(13'o17547, 1'b1, 1'b1, 16'h00AB);
    check("bw_c1_dout", {16'h0, iopage_data_out}, 32'hABAB);
    check("bw_c1_lane", {30'h0, iopage_byte_op, iopage_hibyte}, 32'h3);
    tick();
    check("bw_c2_wr", {30'h0, iopage_rd, iopage_wr}, 32'h1);
    tick();
    check("bw_c3_ack_wr", {30'h0, cpu_ack, iopage_wr}, 32'h2);
    tick();
    check("bw_csr", {16'h0, csr}, 32'hAB34);

    // Undecoded read at 0: NXM, no strobes, rdata held
`ifdef IOPAGE_TIMEOUT_EN
    exp_nxm_cycle = 9;
`else
    exp_nxm_cycle = 2;
`endif
    nxm_cycle = 0;
    strobes   = 0;
    do_req(13'o00000, 1'b0, 1'b0, 16'h0000);
    for (int cyc = 1; cyc <= 20; cyc++) begin
      if (iopage_rd || iopage_wr || cpu_ack) strobes++;
      if (cpu_nxm) begin
        nxm_cycle = cyc;
        break;
      end
      tick();
    end
    check("nxm_cycle", nxm_cycle, exp_nxm_cycle);
    check("nxm_no_strobe", strobes, 0);
    check("nxm_rdata_held", {16'h0, cpu_rdata}, 32'h0034);
    tick();
    check("nxm_one_cycle", {30'h0, cpu_nxm, busy}, 32'h0);

    // Odd word address: error in cycle 1, bus lines untouched
    do_req(13'o17547, 1'b0, 1'b0, 16'h0000);
    check("odd_c1", {28'h0, cpu_odd, busy, iopage_rd, iopage_wr}, 32'hC);
    check("odd_c1_addr", {19'h0, iopage_addr}, 32'h0);
    tick();
    check("odd_c2", {30'h0, cpu_odd, busy}, 32'h0);

    // Reset during SETUP
    do_req(13'o17546, 1'b0, 1'b0, 16'h0000);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_setup_after", {27'h0, busy, cpu_ack, cpu_nxm, cpu_odd, iopage_rd}, 32'h0);
    tick();
    check("rst_setup_next", {28'h0, busy, cpu_ack, cpu_nxm, iopage_rd}, 32'h0);

    // Reset during XFER: strobe drops as soon as reset rises
    do_req(13'o17546, 1'b0, 1'b0, 16'h0000);
    tick();
    check("rst_xfer_rd", {31'h0, iopage_rd}, 32'h1);
    reset = 1'b1;
    #1;
    check("rst_xfer_drop", {30'h0, iopage_rd, iopage_wr}, 32'h0);
    tick();
    reset = 1'b0;
    check("rst_xfer_after", {28'h0, busy, cpu_ack, cpu_nxm, cpu_odd}, 32'h0);
    tick();
    check("rst_xfer_next", {30'h0, busy, cpu_ack}, 32'h0);

    // Request after reset completes normally
    do_req(13'o17546, 1'b0, 1'b0, 16'h0000);
    tick();
    tick();
    check("post_rst_read", {15'h0, cpu_ack, cpu_rdata}, 32'h1_AB34);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
